// File: rtl/inputbuffer_line_packer_pkg.sv
// Shared definitions for the input-buffer line packer: FSM encoding and
// helpers that derive the beat-to-word packing ratio from the data widths.
package inputbuffer_line_packer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } lp_state_e;

    localparam int PIC_W = 6;

    // Number of input beats packed into one output word.
    function automatic int pack_ratio(input int dw, input int iw);
        return dw / iw;
    endfunction

    // Width of the beat counter; never below one bit.
    function automatic int cnt_width(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    // The packer needs a whole number of beats per word, and at least two.
    function automatic bit ratio_ok(input int dw, input int iw);
        return (iw > 0) && (dw % iw == 0) && (dw / iw >= 2);
    endfunction

endpackage

// File: rtl/ib_out_reg.sv
// One-entry valid/ready register carrying a data word and its sop/hsync tags.
// A new word may be loaded in the same cycle the held word drains.
module ib_out_reg #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    input  logic         load_sop,
    input  logic         load_hsync,
    output logic         load_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_sop,
    output logic         out_hsync,
    input  logic         out_ready
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         sop_q, sop_d;
    logic         hsync_q, hsync_d;

    assign load_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sop_d   = sop_q;
        hsync_d = hsync_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (load_valid) begin
            valid_d = 1'b1;
            data_d  = load_data;
            sop_d   = load_sop;
            hsync_d = load_hsync;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            hsync_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            hsync_q <= hsync_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sop   = sop_q;
    assign out_hsync = hsync_q;

endmodule

// File: rtl/inputbuffer_line_packer.sv
// Packs narrow pixel beats into input-buffer words and frames them into
// pic_size x pic_size words, tagging start-of-frame and end-of-row.
module inputbuffer_line_packer
    import inputbuffer_line_packer_pkg::*;
#(
    parameter int dw = 128,
    parameter int iw = 32,
    parameter int aw = 10
) (
    input  logic             SYS_CLK,
    input  logic             SYS_RST,
    input  logic             cfg_start,
    input  logic [PIC_W-1:0] cfg_pic_size,
    input  logic [aw-1:0]    cfg_addr_start,
    input  logic [iw-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [dw-1:0]    input_buffer_write_data,
    output logic             input_buffer_write_valid,
    input  logic             input_buffer_write_ready,
    output logic             input_buffer_write_sop,
    output logic             input_buffer_write_hsync,
    output logic [aw-1:0]    input_buffer_write_addr_start,
    output logic             busy,
    output logic             frame_done
);

    localparam int R  = pack_ratio(dw, iw);
    localparam int RW = cnt_width(R);
    localparam logic [RW-1:0] BEAT_LAST = RW'(R - 1);

    if (!ratio_ok(dw, iw)) begin : g_bad_ratio
        $error("inputbuffer_line_packer: dw must be a multiple (>=2) of iw");
    end

    lp_state_e          state_q, state_d;
    logic [PIC_W-1:0]   pic_size_q, pic_size_d;
    logic [aw-1:0]      addr_start_q, addr_start_d;
    logic [RW-1:0]      beat_cnt_q, beat_cnt_d;
    logic [PIC_W-1:0]   col_cnt_q, col_cnt_d;
    logic [PIC_W-1:0]   row_cnt_q, row_cnt_d;
    logic               sop_pending_q, sop_pending_d;
    logic               frame_done_q, frame_done_d;
    logic [dw-iw-1:0]   pack_q, pack_d;

    logic               accept;
    logic               word_load;
    logic               load_ready;
    logic               col_last;
    logic               row_last;
    logic [dw-1:0]      load_data;

    assign in_ready  = (state_q == RUN) && ((beat_cnt_q != BEAT_LAST) || load_ready);
    assign accept    = in_valid && in_ready;
    assign word_load = accept && (beat_cnt_q == BEAT_LAST);
    assign col_last  = (col_cnt_q == pic_size_q - 6'd1);
    assign row_last  = (row_cnt_q == pic_size_q - 6'd1);

    // Lower slots come from the pack register; the final beat bypasses it
    // so the word is complete on the same edge that accepts that beat.
    for (genvar gi = 0; gi < R - 1; gi++) begin : g_slot
        assign pack_d[gi*iw +: iw]    = (accept && beat_cnt_q == RW'(gi)) ? in_data
                                                                           : pack_q[gi*iw +: iw];
        assign load_data[gi*iw +: iw] = pack_q[gi*iw +: iw];
    end
    assign load_data[dw-1 -: iw] = in_data;

    always_comb begin
        state_d       = state_q;
        pic_size_d    = pic_size_q;
        addr_start_d  = addr_start_q;
        beat_cnt_d    = beat_cnt_q;
        col_cnt_d     = col_cnt_q;
        row_cnt_d     = row_cnt_q;
        sop_pending_d = sop_pending_q;
        frame_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start && cfg_pic_size != '0) begin
                    state_d       = RUN;
                    pic_size_d    = cfg_pic_size;
                    addr_start_d  = cfg_addr_start;
                    beat_cnt_d    = '0;
                    col_cnt_d     = '0;
                    row_cnt_d     = '0;
                    sop_pending_d = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    beat_cnt_d = (beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + 1'b1;
                end
                if (word_load) begin
                    sop_pending_d = 1'b0;
                    if (col_last) begin
                        col_cnt_d = '0;
                        row_cnt_d = row_cnt_q + 6'd1;
                        if (row_last) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        col_cnt_d = col_cnt_q + 6'd1;
                    end
                end
            end
            DRAIN: begin
                if (input_buffer_write_valid && input_buffer_write_ready) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state_q       <= IDLE;
            pic_size_q    <= '0;
            addr_start_q  <= '0;
            beat_cnt_q    <= '0;
            col_cnt_q     <= '0;
            row_cnt_q     <= '0;
            sop_pending_q <= 1'b0;
            frame_done_q  <= 1'b0;
            pack_q        <= '0;
        end else begin
            state_q       <= state_d;
            pic_size_q    <= pic_size_d;
            addr_start_q  <= addr_start_d;
            beat_cnt_q    <= beat_cnt_d;
            col_cnt_q     <= col_cnt_d;
            row_cnt_q     <= row_cnt_d;
            sop_pending_q <= sop_pending_d;
            frame_done_q  <= frame_done_d;
            pack_q        <= pack_d;
        end
    end

    ib_out_reg #(
        .W (dw)
    ) u_out_reg (
        .clk        (SYS_CLK),
        .srst       (SYS_RST),
        .load_valid (word_load),
        .load_data  (load_data),
        .load_sop   (sop_pending_q),
        .load_hsync (col_last),
        .load_ready (load_ready),
        .out_valid  (input_buffer_write_valid),
        .out_data   (input_buffer_write_data),
        .out_sop    (input_buffer_write_sop),
        .out_hsync  (input_buffer_write_hsync),
        .out_ready  (input_buffer_write_ready)
    );

    assign input_buffer_write_addr_start = addr_start_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_inputbuffer_line_packer.sv
// Self-checking bench for inputbuffer_line_packer: random beats are framed by a
// queue-based reference model and compared word by word at the output port.
module tb_inputbuffer_line_packer;

    logic         SYS_CLK = 1'b0;
    logic         SYS_RST;
    logic         cfg_start;
    logic [5:0]   cfg_pic_size;
    logic [9:0]   cfg_addr_start;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] wdata;
    logic         wvalid;
    logic         wready;
    logic         wsop;
    logic         whsync;
    logic [9:0]   waddr;
    logic         busy;
    logic         frame_done;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] last_addr = '0;

    inputbuffer_line_packer #(.dw(128), .iw(32), .aw(10)) dut (
        .SYS_CLK                       (SYS_CLK),
        .SYS_RST                       (SYS_RST),
        .cfg_start                     (cfg_start),
        .cfg_pic_size                  (cfg_pic_size),
        .cfg_addr_start                (cfg_addr_start),
        .in_data                       (in_data),
        .in_valid                      (in_valid),
        .in_ready                      (in_ready),
        .input_buffer_write_data       (wdata),
        .input_buffer_write_valid      (wvalid),
        .input_buffer_write_ready      (wready),
        .input_buffer_write_sop        (wsop),
        .input_buffer_write_hsync      (whsync),
        .input_buffer_write_addr_start (waddr),
        .busy                          (busy),
        .frame_done                    (frame_done)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one frame: ps*ps words from 4*ps*ps beats. vmode 0 = continuous
    // valid, else random gaps. rmode 0 = ready high, 1 = low for 5 cycles after
    // the first valid, 2 = random.
    task automatic run_frame(input string name, input int ps, input logic [9:0] addr,
                             input bit seq, input int vmode, input int rmode,
                             input bit mid_start);
        logic [31:0]  beats[$];
        logic [127:0] exp_w;
        logic [129:0] held_v;
        logic         held;
        int nb, sent, words, cyc, first_v, last_hs, stall_beats, max_stall, idle;
        bit done;
        nb = 4 * ps * ps;
        for (int i = 0; i < nb; i++) beats.push_back(seq ? 32'(i) : $urandom);
        sent = 0; words = 0; cyc = 0; first_v = -1; last_hs = -100;
        stall_beats = 0; max_stall = 0; idle = 0; done = 0; held = 0; held_v = '0;

        @(posedge SYS_CLK); #1;
        cfg_start = 1'b1; cfg_pic_size = 6'(ps); cfg_addr_start = addr;
        @(posedge SYS_CLK); #1;
        cfg_start = 1'b0; cfg_pic_size = 6'($urandom); cfg_addr_start = 10'($urandom);

        while (!done && cyc < 4000) begin
            in_valid = (sent < nb) && (vmode == 0 || $urandom_range(0, 3) != 0);
            in_data  = (sent < nb) ? beats[sent] : 32'($urandom);
            case (rmode)
                0:       wready = 1'b1;
                1:       wready = (first_v >= 0) && (cyc >= first_v + 5);
                default: wready = ($urandom_range(0, 2) != 0);
            endcase
            if (mid_start && cyc == 10) begin
                cfg_start = 1'b1; cfg_pic_size = 6'd3; cfg_addr_start = ~addr;
            end else begin
                cfg_start = 1'b0;
            end
            @(negedge SYS_CLK);
            if (cyc == 0) begin
                checks++;
                if (busy !== 1'b1 || waddr !== addr) begin
                    errors++;
                    $display("FAIL %s start: busy=%b addr=%h required busy=1 addr=%h", name, busy, waddr, addr);
                end
            end
            if (held) begin
                checks++;
                if ({wvalid, wdata, wsop, whsync} !== {1'b1, held_v}) begin
                    errors++;
                    $display("FAIL %s hold_stable: valid=%b data=%h sop=%b hsync=%b required held data=%h",
                             name, wvalid, wdata, wsop, whsync, held_v[129:2]);
                end
            end
            if (wvalid && first_v < 0) first_v = cyc;
            if (in_valid && in_ready) begin
                if (wvalid && !wready) stall_beats++;
                if (stall_beats > max_stall) max_stall = stall_beats;
                sent++;
            end else if (in_valid && sent > 0) begin
                idle++;
            end
            if (wvalid && wready) begin
                $display("%s word %0d data=%h sop=%b hsync=%b addr=%h", name, words, wdata, wsop, whsync, waddr);
                if (words >= ps * ps) begin
                    checks++; errors++;
                    $display("FAIL %s extra_word: got word %0d required at most %0d", name, words, ps * ps);
                end else begin
                    for (int j = 0; j < 4; j++) exp_w[j*32 +: 32] = beats[4*words + j];
                    checks++;
                    if (wdata !== exp_w) begin
                        errors++;
                        $display("FAIL %s word%0d_data: got %h required %h", name, words, wdata, exp_w);
                    end
                    checks++;
                    if (wsop !== (words == 0)) begin
                        errors++;
                        $display("FAIL %s word%0d_sop: got %b required %b", name, words, wsop, words == 0);
                    end
                    checks++;
                    if (whsync !== ((words % ps) == ps - 1)) begin
                        errors++;
                        $display("FAIL %s word%0d_hsync: got %b required %b", name, words, whsync, (words % ps) == ps - 1);
                    end
                    checks++;
                    if (waddr !== addr) begin
                        errors++;
                        $display("FAIL %s word%0d_addr: got %h required %h", name, words, waddr, addr);
                    end
                    if (vmode == 0 && rmode == 0 && words > 0) begin
                        checks++;
                        if (cyc - last_hs != 4) begin
                            errors++;
                            $display("FAIL %s word%0d_spacing: got %0d cycles required 4", name, words, cyc - last_hs);
                        end
                    end
                end
                last_hs = cyc;
                words++;
                stall_beats = 0;
            end
            held   = wvalid && !wready;
            held_v = {wdata, wsop, whsync};
            if (frame_done) begin
                checks++;
                if (cyc != last_hs + 1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s frame_done_timing: at cycle %0d busy=%b required cycle %0d busy=0",
                             name, cyc, busy, last_hs + 1);
                end
                done = 1;
            end
            @(posedge SYS_CLK); #1;
            cyc++;
        end
        in_valid = 1'b0;
        wready   = 1'b1;
        cfg_start = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: no frame_done after %0d cycles", name, cyc);
        end
        checks++;
        if (sent != nb || words != ps * ps) begin
            errors++;
            $display("FAIL %s counts: beats=%0d words=%0d required beats=%0d words=%0d", name, sent, words, nb, ps * ps);
        end
        if (rmode == 1) begin
            checks++;
            if (max_stall != 3) begin
                errors++;
                $display("FAIL %s stall_beats: got %0d required 3", name, max_stall);
            end
        end else begin
            checks++;
            if (max_stall > 3) begin
                errors++;
                $display("FAIL %s stall_beats: got %0d required <=3", name, max_stall);
            end
        end
        if (vmode == 0 && rmode == 0) begin
            checks++;
            if (idle != 0) begin
                errors++;
                $display("FAIL %s idle_inputs: got %0d required 0", name, idle);
            end
        end
        @(negedge SYS_CLK);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_frame: frame_done=%b busy=%b required 0 0", name, frame_done, busy);
        end
        @(posedge SYS_CLK); #1;
        last_addr = addr;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({wvalid, wdata, wsop, whsync, waddr, busy, in_ready, frame_done} !== '0) begin
            errors++;
            $display("FAIL %s outputs_zero: valid=%b data=%h sop=%b hsync=%b addr=%h busy=%b in_ready=%b done=%b required all 0",
                     name, wvalid, wdata, wsop, whsync, waddr, busy, in_ready, frame_done);
        end
    endtask

    task automatic test_reset();
        SYS_RST = 1'b1;
        repeat (3) @(posedge SYS_CLK);
        #1 SYS_RST = 1'b0;
        @(negedge SYS_CLK);
        check_all_zero("reset");
        @(posedge SYS_CLK); #1;
    endtask

    task automatic test_basic();
        run_frame("basic", 2, 10'h040, 1'b1, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame("backpressure", 2, 10'h040, 1'b1, 0, 1, 1'b0);
    endtask

    task automatic test_single_word();
        run_frame("single", 1, 10'h3A5, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_illegal_start();
        cfg_start = 1'b1; cfg_pic_size = 6'd0; cfg_addr_start = 10'h2AA;
        @(posedge SYS_CLK); #1;
        cfg_start = 1'b0;
        @(negedge SYS_CLK);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || waddr !== last_addr) begin
            errors++;
            $display("FAIL size0_start: busy=%b in_ready=%b addr=%h required 0 0 %h", busy, in_ready, waddr, last_addr);
        end
        @(posedge SYS_CLK); #1;
        run_frame("midstart", 2, 10'h0C3, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        cfg_start = 1'b1; cfg_pic_size = 6'd2; cfg_addr_start = 10'h155;
        @(posedge SYS_CLK); #1;
        cfg_start = 1'b0;
        wready   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = $urandom;
            @(posedge SYS_CLK); #1;
        end
        in_valid = 1'b0;
        SYS_RST  = 1'b1;
        @(posedge SYS_CLK); #1;
        SYS_RST  = 1'b0;
        wready   = 1'b1;
        @(negedge SYS_CLK);
        check_all_zero("reset_mid");
        for (int i = 0; i < 4; i++) begin
            @(negedge SYS_CLK);
            checks++;
            if (frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_done: frame_done=%b required 0", frame_done);
            end
        end
        @(posedge SYS_CLK); #1;
        last_addr = '0;
        run_frame("after_reset", 2, 10'h040, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_throughput();
        run_frame("throughput", 4, 10'h111, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            run_frame("random", $urandom_range(1, 5), 10'($urandom), 1'b0, 1, 2, 1'b0);
        end
    endtask

    initial begin
        SYS_RST = 1'b1; cfg_start = 1'b0; cfg_pic_size = '0; cfg_addr_start = '0;
        in_data = '0; in_valid = 1'b0; wready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_single_word();
        test_illegal_start();
        test_reset_mid_frame();
        test_throughput();
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inputbuffer_line_packer.md
Name: inputbuffer_line_packer

Overview:
- Upstream feeder of the input buffer write port. Takes a narrow pixel-word stream from the DMA/loader and packs dw/iw input beats into one dw-bit input-buffer word.
- Frames the stream into rows and frames. Generates write_valid, write_sop, write_hsync and write_addr_start, and honours input_buffer_write_ready backpressure.
- One frame is pic_size rows of pic_size output words each.

Parameters:
- dw, 128, output word width; must equal the input buffer data width.
- iw, 32, input beat width; dw must be an integer multiple of iw. Default ratio R = dw/iw = 4.
- aw, 10, input buffer address width.

Ports:
- SYS_CLK  in  1  clock, all logic on the rising edge.
- SYS_RST  in  1  synchronous reset, active-high.
- cfg_start  in  1  one-cycle pulse; latches the configuration and begins a frame.
- cfg_pic_size  in  6  row length in output words, and row count.
- cfg_addr_start  in  aw  base address forwarded with the frame.
- in_data  in  iw  pixel beat; lowest beat occupies bits [iw-1:0] of the packed word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- input_buffer_write_data  out  dw  packed word.
- input_buffer_write_valid  out  1  packed word valid.
- input_buffer_write_ready  in  1  consumer ready.
- input_buffer_write_sop  out  1  high with the first word of the frame.
- input_buffer_write_hsync  out  1  high with the last word of each row.
- input_buffer_write_addr_start  out  aw  latched cfg_addr_start, stable for the whole frame.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse after the last word of the frame is accepted.

Behaviour:
- Reset:
  - All outputs reset to 0; the FSM resets to IDLE.
  - Counters and the pack register reset to 0.
  - Reset mid-frame discards any partial pack and any pending output word; no frame_done is produced.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on cfg_start with cfg_pic_size != 0. This latches pic_size and addr_start, clears beat_cnt, col_cnt and row_cnt, and sets the sop_pending flag.
  - cfg_start with size 0 is ignored. cfg_start while busy is ignored.
  - RUN -> DRAIN when the final input beat of the frame is accepted, i.e. beat_cnt = R-1, col_cnt = pic_size-1 and row_cnt = pic_size-1.
  - DRAIN -> IDLE when the output word is handshaken. frame_done pulses in the cycle after that handshake.
- busy is 1 in RUN and DRAIN. in_ready is 0 in IDLE and DRAIN.
- Packing:
  - The beat_cnt (log2 R bits) slot of the pack register takes in_data on each accepted beat.
  - On the R-th beat, the completed word (the pack register plus the current beat) is loaded into a single output register in the same edge.
  - write_valid rises the next cycle. Latency from the last input beat to valid is 1 cycle.
- Output register handshake:
  - Holds data, sop and hsync stable until valid & ready.
  - in_ready = RUN & (beat_cnt != R-1 | !write_valid | write_ready). Full throughput is 1 beat per cycle with no bubble under continuous ready.
  - Simultaneous load and drain in the same cycle is legal and required.
- Flag tagging:
  - sop is tagged on the first word loaded while sop_pending = 1; sop_pending then clears.
  - hsync is tagged on the word whose col_cnt = pic_size-1.
  - A pic_size = 1 frame has sop and hsync on the same word.
- Counters:
  - col_cnt increments on each word load and wraps to 0 at pic_size-1.
  - row_cnt increments on each col_cnt wrap.
  - Comparisons are 6-bit unsigned with no overflow, since pic_size ≤ 63.
- write_addr_start is driven from the latched value and changes only on an accepted cfg_start.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=0, RUN=1, DRAIN=2).
  - Derived constant R = dw/iw and its bit width.
  - An elaboration-time check that dw % iw == 0.
- One natural sub-module, ib_out_reg: the 1-entry valid/ready output register that holds data, sop and hsync. It is reusable elsewhere in the input buffer datapath. Everything else stays flat.

Test Plan:
- Basic frame:
  - Stimulus: cfg_pic_size=2, cfg_addr_start=0x040; 16 beats with values 0..15, in_valid and ready held high.
  - Required response:
    - 4 words are produced; word0 = {3,2,1,0} with sop=1.
    - word1 and word3 have hsync=1.
    - addr_start = 0x040 throughout.
    - frame_done occurs 1 cycle after the word3 handshake; busy then falls.
- Backpressure:
  - Stimulus: same frame with write_ready held low for 5 cycles after the first valid.
  - Required response:
    - word0 stays stable.
    - in_ready drops when beat_cnt = 3; at most 3 extra beats are accepted.
    - No loss or duplication across the full frame.
- Single word frame:
  - Stimulus: cfg_pic_size=1, 4 beats.
  - Required response: exactly 1 word with sop=1 and hsync=1; then IDLE.
- Illegal start:
  - Stimulus: cfg_start with size 0; then cfg_start with size 3 mid-frame of a size-2 run.
  - Required response:
    - The size-0 start is ignored, busy stays 0.
    - The mid-frame start is ignored; the size-2 frame completes with addr_start unchanged.
- Reset mid-frame:
  - Stimulus: SYS_RST asserted after 6 beats.
  - Required response:
    - Next cycle all outputs are 0, busy=0, no frame_done.
    - A new size-2 frame then produces a correct word0 with sop.
- Throughput:
  - Stimulus: size 4 with in_valid and ready continuously high.
  - Required response: 64 beats yield 16 words, one valid word every 4 cycles, with zero idle input cycles.
